sensor_scheduler: RTL and testbench

SENSOR_SCHEDULER -- requirements
Module: sensor_scheduler

---
 rtl/sensor_pkg.sv | 26 ++
 rtl/sweep_timer.sv | 45 ++++
 rtl/sensor_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_sensor_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared types and default constants for the sensor sweep scheduler.
// The state encoding is kept here so the block and its bench agree on names.
package sensor_pkg;

  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_PERIOD    = 1000;
  localparam int DEF_TIMEOUT   = 4096;
  localparam int ADDR_W        = 7;
  localparam int DATA_W        = 8;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WR_REQ,
    WR_GAP,
    RD_REQ,
    RD_GAP,
    NEXT
  } state_t;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sweep_timer.sv
// Free-running sweep period counter plus the pending-sweep request flag.
// Periodic wraps and manual triggers merge into a single pending request.
module sweep_timer
  import sensor_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic trigger,
  input  logic clear,
  output logic pending
);

  localparam int CW = cnt_width(PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = run && (cnt == CNT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A new request on the same edge the FSM consumes one must not be lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else begin
      pending <= (pending && !clear) || wrap || trigger;
    end
  end

endmodule

// File: rtl/sensor_scheduler.sv
// Sweeps enabled sensor slots: writes each slot's config byte, then reads it
// back through an external I2C master, recording results and timeouts.
module sensor_scheduler
  import sensor_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        trigger,
  input  logic [NUM_SLOTS-1:0]        slot_en,
  input  logic [ADDR_W*NUM_SLOTS-1:0] slot_addr,
  input  logic [DATA_W*NUM_SLOTS-1:0] slot_cfg,
  output logic                        start,
  output logic                        mode,
  output logic [ADDR_W-1:0]           sensor_address,
  output logic [DATA_W-1:0]           write_val,
  input  logic                        data_ready,
  input  logic [DATA_W-1:0]           read_val,
  output logic [DATA_W*NUM_SLOTS-1:0] result,
  output logic [NUM_SLOTS-1:0]        valid,
  output logic [NUM_SLOTS-1:0]        err,
  output logic                        busy,
  output logic                        sweep_done
);

  localparam int IW = cnt_width(NUM_SLOTS);
  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLOTS - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] tcnt_q;
  logic          pending;

  logic sweep_begin, sel_load, rd_load, capture, set_err, idx_inc, tcnt_clr;
  logic timed_out;

  sweep_timer #(.PERIOD(PERIOD)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .trigger (trigger),
    .clear   (sweep_begin),
    .pending (pending)
  );

  assign timed_out  = (tcnt_q == T_LAST);
  assign start      = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign busy       = (state_q != IDLE);
  assign sweep_done = (state_q == NEXT) && (idx_q == LAST_IDX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    sweep_begin = 1'b0;
    sel_load    = 1'b0;
    rd_load     = 1'b0;
    capture     = 1'b0;
    set_err     = 1'b0;
    idx_inc     = 1'b0;
    tcnt_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending) begin
          sweep_begin = 1'b1;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        // Disabled slots cost one cycle each; the last one falls into NEXT.
        if (slot_en[idx_q]) begin
          sel_load = 1'b1;
          tcnt_clr = 1'b1;
          state_d  = WR_REQ;
        end else if (idx_q < LAST_IDX) begin
          idx_inc = 1'b1;
        end else begin
          state_d = NEXT;
        end
      end
      WR_REQ: begin
        if (data_ready) begin
          state_d = WR_GAP;
        end else if (timed_out) begin
          set_err = 1'b1;
          state_d = NEXT;
        end
      end
      WR_GAP: begin
        if (!data_ready) begin
          rd_load  = 1'b1;
          tcnt_clr = 1'b1;
          state_d  = RD_REQ;
        end
      end
      RD_REQ: begin
        if (data_ready) begin
          capture = 1'b1;
          state_d = RD_GAP;
        end else if (timed_out) begin
          set_err = 1'b1;
          state_d = NEXT;
        end
      end
      RD_GAP: begin
        if (!data_ready) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (idx_q < LAST_IDX) begin
          idx_inc = 1'b1;
          state_d = SELECT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: result is a flop bank rather than a RAM, so it is reset along with
  // everything else and never shows stale data after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q          <= '0;
      tcnt_q         <= '0;
      mode           <= 1'b0;
      sensor_address <= '0;
      write_val      <= '0;
      result         <= '0;
      valid          <= '0;
      err            <= '0;
    end else begin
      if (sweep_begin) begin
        idx_q <= '0;
      end else if (idx_inc) begin
        idx_q <= idx_q + 1'b1;
      end

      if (tcnt_clr) begin
        tcnt_q <= '0;
      end else if (start) begin
        tcnt_q <= tcnt_q + 1'b1;
      end

      if (sweep_begin) begin
        valid <= valid & ~slot_en;
        err   <= err & ~slot_en;
      end

      // Slot settings are latched here so mid-sweep edits wait for SELECT.
      if (sel_load) begin
        mode           <= 1'b1;
        sensor_address <= slot_addr[idx_q*ADDR_W +: ADDR_W];
        write_val      <= slot_cfg[idx_q*DATA_W +: DATA_W];
      end
      if (rd_load) begin
        mode <= 1'b0;
      end

      if (capture) begin
        result[idx_q*DATA_W +: DATA_W] <= read_val;
        valid[idx_q]                   <= 1'b1;
      end
      if (set_err) begin
        err[idx_q] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sensor_scheduler.sv
// Scoreboard bench for sensor_scheduler: a behavioural slave answers the
// master handshake, a reference model predicts transactions and sweep results.
module tb_sensor_scheduler;
  import sensor_pkg::*;

  localparam int N   = 4;
  localparam int PER = 1000;
  localparam int TO  = 64;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           run = 1'b0;
  logic           trigger = 1'b0;
  logic [N-1:0]   slot_en = '0;
  logic [7*N-1:0] slot_addr = '0;
  logic [8*N-1:0] slot_cfg = '0;
  logic           data_ready = 1'b0;
  logic [7:0]     read_val = '0;
  logic           start, mode, busy, sweep_done;
  logic [6:0]     sensor_address;
  logic [7:0]     write_val;
  logic [8*N-1:0] result;
  logic [N-1:0]   valid, err;

  sensor_scheduler #(.NUM_SLOTS(N), .PERIOD(PER), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .run(run), .trigger(trigger),
    .slot_en(slot_en), .slot_addr(slot_addr), .slot_cfg(slot_cfg),
    .start(start), .mode(mode), .sensor_address(sensor_address),
    .write_val(write_val), .data_ready(data_ready), .read_val(read_val),
    .result(result), .valid(valid), .err(err), .busy(busy),
    .sweep_done(sweep_done)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Slave world: per-address readback value, dead addresses never answer.
  logic [7:0] sensor_val [128];
  bit         dead [128];
  bit         stall_rd = 1'b0;

  typedef struct packed {
    logic       mode;
    logic [6:0] addr;
    logic [7:0] wval;
  } txn_t;

  typedef struct packed {
    logic [8*N-1:0] result;
    logic [N-1:0]   valid;
    logic [N-1:0]   err;
  } sweep_t;

  txn_t   txn_q[$];
  sweep_t sweep_q[$];
  int     busy_rise[$];
  logic [8*N-1:0] m_result = '0;
  logic [N-1:0]   m_valid = '0;
  logic [N-1:0]   m_err = '0;

  // Reference model: each enabled slot is a write then, if the sensor lives, a read.
  task automatic predict_sweep();
    txn_t   t;
    sweep_t s;
    for (int i = 0; i < N; i++) begin
      if (slot_en[i]) begin
        logic [6:0] a;
        a = slot_addr[7*i +: 7];
        t.mode = 1'b1; t.addr = a; t.wval = slot_cfg[8*i +: 8];
        txn_q.push_back(t);
        if (dead[a]) begin
          m_err[i]   = 1'b1;
          m_valid[i] = 1'b0;
        end else begin
          t.mode = 1'b0; t.wval = 8'h00;
          txn_q.push_back(t);
          m_result[8*i +: 8] = sensor_val[a];
          m_valid[i] = 1'b1;
          m_err[i]   = 1'b0;
        end
      end
    end
    s.result = m_result; s.valid = m_valid; s.err = m_err;
    sweep_q.push_back(s);
  endtask

  // Behavioural I2C master stand-in.
  initial begin
    logic [6:0] a;
    logic       m;
    forever begin
      @(posedge clock); #1;
      if (start && !reset) begin
        a = sensor_address;
        m = mode;
        if (dead[a] || (stall_rd && !m)) begin
          while (start) begin @(posedge clock); #1; end
        end else begin
          repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
          data_ready = 1'b1;
          read_val   = m ? 8'($urandom) : sensor_val[a];
          while (start) begin @(posedge clock); #1; end
          repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
          data_ready = 1'b0;
          read_val   = 8'($urandom);
        end
      end
    end
  end

  int   cyc = 0;
  int   done_cnt = 0;
  logic prev_start = 1'b0, prev_dr = 1'b0, prev_busy = 1'b0;

  always @(posedge clock) cyc++;

  // Monitor: compares each new request and each completed sweep with the model.
  always @(negedge clock) begin
    txn_t   t;
    sweep_t s;
    if (!reset) begin
      if (start && !prev_start) begin
        check("start_while_ready", prev_dr, 0);
        if (txn_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_start: mode %0b addr %0h, none expected", mode, sensor_address);
        end else begin
          t = txn_q.pop_front();
          check("txn_mode", mode, t.mode);
          check("txn_addr", sensor_address, t.addr);
          if (t.mode) check("txn_wval", write_val, t.wval);
        end
      end
      if (sweep_done) begin
        done_cnt++;
        if (sweep_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_sweep_done: got pulse, none expected");
        end else begin
          s = sweep_q.pop_front();
          check("sweep_result", result, s.result);
          check("sweep_valid", valid, s.valid);
          check("sweep_err", err, s.err);
        end
      end
      if (busy && !prev_busy) busy_rise.push_back(cyc);
    end
    prev_start = start;
    prev_dr    = data_ready;
    prev_busy  = busy;
  end

  initial begin
    repeat (60000) @(posedge clock);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((busy || sweep_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    check({name, "_completes"}, k < budget, 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_start"}, start, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, sweep_done, 0);
    check({name, "_mode_addr_wval"}, {mode, sensor_address, write_val}, 0);
    check({name, "_result"}, result, 0);
    check({name, "_valid_err"}, {valid, err}, 0);
  endtask

  task automatic set_slot(input int i, input logic [6:0] a, input logic [7:0] c);
    slot_addr[7*i +: 7] = a;
    slot_cfg[8*i +: 8]  = c;
  endtask

  logic [6:0] pool [8] = '{7'h10, 7'h21, 7'h32, 7'h43, 7'h54, 7'h65, 7'h5a, 7'h7e};

  initial begin
    int n;
    for (int a = 0; a < 128; a++) begin
      sensor_val[a] = 8'($urandom);
      dead[a] = 1'b0;
    end
    dead[7'h5a] = 1'b1;
    dead[7'h7e] = 1'b1;
    sensor_val[7'h70] = 8'hf0;

    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // Single slot: write f2 to 0x70, read back f0.
    slot_en = 4'b0001;
    set_slot(0, 7'h70, 8'hf2);
    n = done_cnt;
    predict_sweep();
    pulse_trigger();
    wait_idle("single_slot", 500);
    check("single_slot_result", result[7:0], 8'hf0);
    check("single_slot_valid", valid, 4'b0001);
    check("single_slot_pulses", done_cnt - n, 1);

    // No slot enabled: no start, done pulse exactly NUM_SLOTS+2 cycles on.
    slot_en = 4'b0000;
    predict_sweep();
    trigger = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      trigger = 1'b0;
    end while (!sweep_done && n < 20);
    check("empty_sweep_latency", n, N + 2);
    wait_idle("empty_sweep", 100);

    // Slot 2 alive first, then moved to a dead address: its result must hold.
    slot_en = 4'b1111;
    for (int i = 0; i < N; i++) set_slot(i, pool[i], 8'($urandom));
    predict_sweep();
    pulse_trigger();
    wait_idle("all_alive", 1000);
    set_slot(2, 7'h5a, 8'h11);
    predict_sweep();
    pulse_trigger();
    wait_idle("slot2_dead", 1000);
    check("slot2_dead_err", err, 4'b0100);
    check("slot2_dead_valid", valid, 4'b1011);
    check("slot2_dead_result", result[23:16], sensor_val[pool[2]]);

    // Periodic sweeps plus two merged triggers while busy -> one extra sweep.
    set_slot(2, pool[2], 8'h22);
    for (int k = 0; k < 4; k++) predict_sweep();
    busy_rise.delete();
    run = 1'b1;
    n = 0;
    while (busy_rise.size() < 2 && n < 2500) begin tick(); n++; end
    tick(2);
    check("merge_trigger_while_busy", busy, 1);
    pulse_trigger();
    tick(3);
    pulse_trigger();
    n = 0;
    while (busy_rise.size() < 4 && n < 1500) begin tick(); n++; end
    run = 1'b0;
    wait_idle("periodic", 1500);
    tick(50);
    check("periodic_sweep_count", busy_rise.size(), 4);
    if (busy_rise.size() >= 4) begin
      check("period_interval_1", busy_rise[1] - busy_rise[0], PER);
      check("period_interval_2", busy_rise[3] - busy_rise[1], PER);
    end

    // Reset while waiting on a read: start drops at once, then a clean sweep.
    slot_en  = 4'b0001;
    set_slot(0, pool[4], 8'h5c);
    stall_rd = 1'b1;
    predict_sweep();
    pulse_trigger();
    n = 0;
    while (!(start && !mode) && n < 100) begin tick(); n++; end
    check("reach_rd_req", start && !mode, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_all_zero("mid_read_reset");
    txn_q.delete();
    sweep_q.delete();
    m_result = '0;
    m_valid  = '0;
    m_err    = '0;
    stall_rd = 1'b0;
    tick(2);
    reset = 1'b0;
    tick();
    predict_sweep();
    pulse_trigger();
    wait_idle("after_reset", 500);
    check("after_reset_result", result[7:0], sensor_val[pool[4]]);

    // Randomized sweeps over a pool containing live and dead sensors.
    for (int it = 0; it < 25; it++) begin
      slot_en = N'($urandom);
      for (int i = 0; i < N; i++) set_slot(i, pool[$urandom_range(0, 7)], 8'($urandom));
      for (int p = 0; p < 6; p++) sensor_val[pool[p]] = 8'($urandom);
      predict_sweep();
      pulse_trigger();
      wait_idle("random_sweep", 2000);
      tick($urandom_range(0, 3));
    end

    check("leftover_txns", txn_q.size(), 0);
    check("leftover_sweeps", sweep_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
